// File: rtl/ad_cache_sched_pkg.sv
// Shared types and header-format constants for the ad_cache readout scheduler.
package ad_sched_pkg;

  localparam int USB_DATA_NBIT    = 16;
  localparam int AD_CHE_ADDR_NBIT = 3;
  localparam int CH_W             = 4;

  localparam logic [7:0] HDR_TAG_DEF = 8'hA5;
  localparam int HDR_TAG_LSB = 8;
  localparam int HDR_SEQ_LSB = 4;
  localparam int HDR_CH_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_READ,
    ST_DRAIN
  } sched_state_e;

  function automatic logic [15:0] make_header(input logic [7:0] tag,
                                              input logic [3:0] seq,
                                              input logic [3:0] ch);
    logic [15:0] h;
    h = '0;
    h[HDR_TAG_LSB +: 8] = tag;
    h[HDR_SEQ_LSB +: 4] = seq;
    h[HDR_CH_LSB  +: 4] = ch;
    return h;
  endfunction

endpackage

// File: rtl/ad_cache_sched_if.sv
// Channel read ports and USB slave-FIFO write port seen by the scheduler.
interface ad_cache_sched_if
  import ad_sched_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int DW   = USB_DATA_NBIT
);
  logic [N_CH-1:0]    sw;
  logic [N_CH*DW-1:0] rdata;
  logic [N_CH-1:0]    rd;
  logic               usb_afull;
  logic               usb_wr;
  logic [DW-1:0]      usb_data;

  modport master (
    input  sw, rdata, usb_afull,
    output rd, usb_wr, usb_data
  );

  modport slave (
    output sw, rdata, usb_afull,
    input  rd, usb_wr, usb_data
  );
endinterface

// File: rtl/ad_cache_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first request found after 'last', wrapping.
module rr_arbiter
  import ad_sched_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]    req,
  input  logic [CH_W-1:0] last,
  output logic [N-1:0]    gnt,
  output logic [CH_W-1:0] gnt_idx,
  output logic            gnt_vld
);

  // Walk offsets from farthest to nearest so the nearest request wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int i = N; i >= 1; i--) begin
      if (req[(int'(last) + i) % N]) begin
        gnt     = '0;
        gnt[(int'(last) + i) % N] = 1'b1;
        gnt_idx = CH_W'((int'(last) + i) % N);
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ad_cache_sched.sv
// Round-robin readout of N ad_cache half-buffers into the USB slave FIFO,
// one header word plus one full half-buffer per grant, with overrun counting.
module ad_cache_sched
  import ad_sched_pkg::*;
#(
  parameter int         N_CH      = 4,
  parameter int         DW        = USB_DATA_NBIT,
  parameter int         BLK_WORDS = 1 << AD_CHE_ADDR_NBIT,
  parameter int         RD_LAT    = 2,
  parameter logic [7:0] HDR_TAG   = HDR_TAG_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  ad_cache_sched_if.master     bus,
  output logic                 busy,
  output logic [N_CH*8-1:0]    ovr_cnt
);

  localparam int IW = $clog2(BLK_WORDS + 1);

  sched_state_e        state_q, state_d;
  logic [N_CH-1:0]     pend_q, pend_d, pend_clr;
  logic [CH_W-1:0]     ch_q, ch_d, last_q, last_d;
  logic [3:0]          seq_q, seq_d;
  logic [IW-1:0]       issued_q, issued_d;
  logic [RD_LAT-1:0]   vld_q, vld_d;
  logic                usb_wr_q, usb_wr_d;
  logic [DW-1:0]       usb_data_q, usb_data_d;
  logic [N_CH*8-1:0]   ovr_q, ovr_d;

  logic [N_CH-1:0]     gnt;
  logic [CH_W-1:0]     gnt_idx;
  logic                gnt_vld;
  logic                rd_issue;

  rr_arbiter #(.N(N_CH)) u_arb (
    .req     (pend_q),
    .last    (last_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign rd_issue = (state_q == ST_READ) && !bus.usb_afull;
  assign vld_d    = (vld_q << 1) | RD_LAT'(rd_issue);

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    last_d     = last_q;
    seq_d      = seq_q;
    issued_d   = issued_q;
    pend_clr   = '0;
    usb_wr_d   = 1'b0;
    usb_data_d = usb_data_q;
    case (state_q)
      ST_IDLE: begin
        if (en && gnt_vld) begin
          ch_d     = gnt_idx;
          last_d   = gnt_idx;
          pend_clr = gnt;
          issued_d = '0;
          state_d  = ST_HDR;
        end
      end
      ST_HDR: begin
        if (!bus.usb_afull) begin
          usb_wr_d   = 1'b1;
          usb_data_d = DW'(make_header(HDR_TAG, seq_q, ch_q));
          seq_d      = seq_q + 4'd1;
          state_d    = ST_READ;
        end
      end
      ST_READ: begin
        if (rd_issue) begin
          issued_d = issued_q + 1'b1;
          if (issued_q == IW'(BLK_WORDS - 1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // The final data word must have left the output register too.
        if (vld_q == '0 && !usb_wr_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (vld_q[RD_LAT-1]) begin
      usb_wr_d   = 1'b1;
      usb_data_d = bus.rdata[int'(ch_q)*DW +: DW];
    end
  end

  // A new switch beats the grant-clear, so an overrun block is still read out.
  always_comb begin
    pend_d = pend_q & ~pend_clr;
    ovr_d  = ovr_q;
    for (int c = 0; c < N_CH; c++) begin
      if (bus.sw[c] &&
          (pend_q[c] || (ch_q == CH_W'(c) && (state_q == ST_HDR || state_q == ST_READ))) &&
          ovr_q[c*8 +: 8] != 8'hFF)
        ovr_d[c*8 +: 8] = ovr_q[c*8 +: 8] + 8'd1;
    end
    if (en) pend_d = pend_d | bus.sw;
    else    pend_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pend_q     <= '0;
      ch_q       <= '0;
      last_q     <= CH_W'(N_CH - 1);
      seq_q      <= '0;
      issued_q   <= '0;
      vld_q      <= '0;
      usb_wr_q   <= 1'b0;
      usb_data_q <= '0;
      ovr_q      <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      ch_q       <= ch_d;
      last_q     <= last_d;
      seq_q      <= seq_d;
      issued_q   <= issued_d;
      vld_q      <= vld_d;
      usb_wr_q   <= usb_wr_d;
      usb_data_q <= usb_data_d;
      ovr_q      <= ovr_d;
    end
  end

  assign bus.rd       = rd_issue ? (N_CH'(1) << ch_q) : '0;
  assign bus.usb_wr   = usb_wr_q;
  assign bus.usb_data = usb_data_q;
  assign busy         = (state_q != ST_IDLE);
  assign ovr_cnt      = ovr_q;

endmodule

// File: tb/tb_ad_cache_sched.sv
// Scenario bench for ad_cache_sched with a modelled ad_cache read side and a
// block-level reference model of the expected USB word stream.
module tb_ad_cache_sched;

  localparam int N_CH   = 4;
  localparam int DW     = 16;
  localparam int BLK    = 8;
  localparam int RD_LAT = 2;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic busy;
  logic [N_CH*8-1:0] ovr_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  ad_cache_sched_if #(.N_CH(N_CH), .DW(DW)) bus ();

  ad_cache_sched #(
    .N_CH(N_CH), .DW(DW), .BLK_WORDS(BLK), .RD_LAT(RD_LAT), .HDR_TAG(8'hA5)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .bus(bus), .busy(busy), .ovr_cnt(ovr_cnt)
  );

  always #5 clk = ~clk;

  // Channel model: each rd consumes one ramp word, visible RD_LAT cycles later.
  logic [15:0] base [N_CH];
  int unsigned env_cnt   [N_CH] = '{default: 0};
  int unsigned env_cnt_d [N_CH] = '{default: 0};

  always @(posedge clk) begin
    for (int c = 0; c < N_CH; c++) begin
      env_cnt[c]   <= env_cnt[c] + int'(bus.rd[c]);
      env_cnt_d[c] <= env_cnt[c];
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_env
    assign bus.rdata[g*DW +: DW] = base[g] + 16'(env_cnt_d[g]) - 16'd1;
  end

  // FIFO-side monitor.
  logic [15:0] got_q [$];
  int   lag_viol = 0;
  int   afull_run = 0;
  logic afull_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst && bus.usb_wr) got_q.push_back(bus.usb_data);
    if (bus.usb_afull) afull_run = afull_prev ? afull_run + 1 : 0;
    afull_prev = bus.usb_afull;
    if (bus.usb_wr && bus.usb_afull && afull_run > RD_LAT + 1) lag_viol++;
  end

  // Reference model: block order, header fields and ramp contents.
  logic [15:0] exp_q [$];
  logic [3:0]  seq_m;
  int          last_m;
  int unsigned rdcnt_m [N_CH] = '{default: 0};

  task automatic model_block(input int c);
    exp_q.push_back({8'hA5, seq_m, 4'(c)});
    for (int k = 0; k < BLK; k++) exp_q.push_back(base[c] + 16'(rdcnt_m[c] + k));
    rdcnt_m[c] += BLK;
    seq_m  = seq_m + 4'd1;
    last_m = c;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; bus.sw = '0; bus.usb_afull = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(1);
    seq_m = 4'd0; last_m = N_CH - 1;
    got_q.delete(); exp_q.delete();
  endtask

  task automatic pulse_sw(input logic [N_CH-1:0] m);
    bus.sw = m;
    cyc(1);
    bus.sw = '0;
  endtask

  task automatic wait_quiet(output bit ok);
    int idle;
    idle = 0; ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      cyc(1);
      if (!busy) idle++; else idle = 0;
      if (idle >= 4) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_rd(input int c, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (bus.rd[c]) begin ok = 1'b1; break; end
      cyc(1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; bus.sw = '0; bus.usb_afull = 1'b0;
    cyc(2);
    tests_run++; if (bus.rd !== 4'h0) begin tests_failed++; $display("[TB] FAIL reset_rd: got %h want 0", bus.rd); end
    tests_run++; if (bus.usb_wr !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_wr: got %b want 0", bus.usb_wr); end
    tests_run++; if (bus.usb_data !== 16'h0) begin tests_failed++; $display("[TB] FAIL reset_data: got %h want 0", bus.usb_data); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    tests_run++; if (ovr_cnt !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_ovr: got %h want 0", ovr_cnt); end
  endtask

  task automatic test_single();
    int busy_cnt, first_wr;
    bit ok;
    do_reset();
    pulse_sw(4'b0100);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_grant_busy: got %b want 0", busy); end
    cyc(1);
    busy_cnt = 0; first_wr = -1;
    for (int i = 0; i < 40; i++) begin
      if (busy) busy_cnt++;
      if (bus.usb_wr && first_wr < 0) first_wr = i;
      cyc(1);
    end
    model_block(2);
    tests_run++; if (busy_cnt !== 13) begin tests_failed++; $display("[TB] FAIL single_busy_len: got %0d want 13", busy_cnt); end
    tests_run++; if (first_wr !== 1) begin tests_failed++; $display("[TB] FAIL single_hdr_time: got %0d want 1", first_wr); end
    pulse_sw(4'b0010);
    wait_quiet(ok);
    model_block(1);
    tests_run++; if (!ok) begin tests_failed++; $display("[TB] FAIL single_timeout: busy=%b", busy); end
    tests_run++; if (got_q.size() !== exp_q.size()) begin tests_failed++; $display("[TB] FAIL single_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests_run++; if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("[TB] FAIL single_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_two_same_cycle();
    bit ok;
    do_reset();
    pulse_sw(4'b1001);
    cyc(3);
    pulse_sw(4'b0010);
    wait_quiet(ok);
    model_block(0); model_block(1); model_block(3);
    tests_run++; if (!ok) begin tests_failed++; $display("[TB] FAIL two_timeout: busy=%b", busy); end
    tests_run++; if (got_q.size() !== exp_q.size()) begin tests_failed++; $display("[TB] FAIL two_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests_run++; if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("[TB] FAIL two_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_throttle();
    int c, idle;
    bit ok;
    got_q.delete(); exp_q.delete(); lag_viol = 0;
    c = $urandom_range(0, N_CH - 1);
    idle = 0; ok = 1'b0;
    bus.sw = 4'(1 << c);
    for (int i = 0; i < 400; i++) begin
      bus.usb_afull = ((i / 3) % 2) == 1;
      cyc(1);
      bus.sw = '0;
      if (!busy) idle++; else idle = 0;
      if (i > 4 && idle >= 4) begin ok = 1'b1; break; end
    end
    bus.usb_afull = 1'b0;
    model_block(c);
    tests_run++; if (!ok) begin tests_failed++; $display("[TB] FAIL throttle_timeout: busy=%b", busy); end
    tests_run++; if (lag_viol !== 0) begin tests_failed++; $display("[TB] FAIL throttle_lag: got %0d late writes want 0", lag_viol); end
    tests_run++; if (got_q.size() !== exp_q.size()) begin tests_failed++; $display("[TB] FAIL throttle_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests_run++; if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("[TB] FAIL throttle_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_overrun();
    bit ok, ok_rd;
    do_reset();
    pulse_sw(4'b0001);
    cyc(1);
    bus.sw = 4'b0010;
    cyc(2);
    bus.sw = '0;
    tests_run++; if (ovr_cnt[15:8] !== 8'd1) begin tests_failed++; $display("[TB] FAIL ovr_pend: got %0d want 1", ovr_cnt[15:8]); end
    wait_rd(1, ok_rd);
    pulse_sw(4'b0010);
    wait_quiet(ok);
    model_block(0); model_block(1); model_block(1);
    tests_run++; if (!(ok && ok_rd)) begin tests_failed++; $display("[TB] FAIL ovr_timeout: quiet=%b rd=%b", ok, ok_rd); end
    tests_run++; if (ovr_cnt[15:8] !== 8'd2) begin tests_failed++; $display("[TB] FAIL ovr_read: got %0d want 2", ovr_cnt[15:8]); end
    tests_run++; if (ovr_cnt[7:0] !== 8'd0) begin tests_failed++; $display("[TB] FAIL ovr_ch0: got %0d want 0", ovr_cnt[7:0]); end
    tests_run++; if (got_q.size() !== exp_q.size()) begin tests_failed++; $display("[TB] FAIL ovr_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests_run++; if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("[TB] FAIL ovr_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_saturate();
    bit ok;
    do_reset();
    bus.sw = 4'b1000;
    cyc(5);
    tests_run++; if (ovr_cnt[31:24] !== 8'd4) begin tests_failed++; $display("[TB] FAIL sat_early: got %0d want 4", ovr_cnt[31:24]); end
    cyc(300);
    tests_run++; if (ovr_cnt[31:24] !== 8'd255) begin tests_failed++; $display("[TB] FAIL sat_cap: got %0d want 255", ovr_cnt[31:24]); end
    bus.sw = '0;
    wait_quiet(ok);
    tests_run++; if (!ok) begin tests_failed++; $display("[TB] FAIL sat_timeout: busy=%b", busy); end
    tests_run++; if (got_q.size() == 0 || (got_q.size() % (BLK + 1)) != 0) begin tests_failed++; $display("[TB] FAIL sat_framing: got %0d words want nonzero multiple of %0d", got_q.size(), BLK + 1); end
    rdcnt_m[3] = env_cnt[3];
    seq_m = seq_m + 4'(got_q.size() / (BLK + 1));
    last_m = 3;
  endtask

  task automatic test_en_drop();
    bit ok, ok_rd;
    got_q.delete(); exp_q.delete();
    pulse_sw(4'b0100);
    pulse_sw(4'b0001);
    wait_rd(2, ok_rd);
    en = 1'b0;
    pulse_sw(4'b0010);
    wait_quiet(ok);
    cyc(20);
    model_block(2);
    tests_run++; if (!(ok && ok_rd)) begin tests_failed++; $display("[TB] FAIL en_timeout: quiet=%b rd=%b", ok, ok_rd); end
    tests_run++; if (got_q.size() !== exp_q.size()) begin tests_failed++; $display("[TB] FAIL en_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests_run++; if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("[TB] FAIL en_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    en = 1'b1;
    cyc(20);
    tests_run++; if (got_q.size() !== BLK + 1) begin tests_failed++; $display("[TB] FAIL en_no_regrant: got %0d words want %0d", got_q.size(), BLK + 1); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL en_busy: got %b want 0", busy); end
  endtask

  task automatic test_random();
    logic [N_CH-1:0] m;
    int idle, start;
    bit ok;
    for (int it = 0; it < 6; it++) begin
      got_q.delete(); exp_q.delete(); lag_viol = 0;
      m = 4'($urandom_range(1, 15));
      idle = 0; ok = 1'b0;
      bus.sw = m;
      for (int i = 0; i < 1000; i++) begin
        bus.usb_afull = ($urandom_range(0, 3) == 0);
        cyc(1);
        bus.sw = '0;
        if (!busy) idle++; else idle = 0;
        if (i > 4 && idle >= 4) begin ok = 1'b1; break; end
      end
      bus.usb_afull = 1'b0;
      start = last_m;
      for (int i = 1; i <= N_CH; i++)
        if (m[(start + i) % N_CH]) model_block((start + i) % N_CH);
      tests_run++; if (!ok) begin tests_failed++; $display("[TB] FAIL rand%0d_timeout: busy=%b", it, busy); end
      tests_run++; if (lag_viol !== 0) begin tests_failed++; $display("[TB] FAIL rand%0d_lag: got %0d want 0", it, lag_viol); end
      tests_run++; if (got_q.size() !== exp_q.size()) begin tests_failed++; $display("[TB] FAIL rand%0d_count: got %0d want %0d", it, got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        tests_run++; if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("[TB] FAIL rand%0d_word[%0d]: got %h want %h", it, i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_rst_mid();
    bit ok, ok_rd;
    pulse_sw(4'b0010);
    wait_rd(1, ok_rd);
    rst = 1'b1;
    #1;
    tests_run++; if (!ok_rd) begin tests_failed++; $display("[TB] FAIL rst_no_read: rd=%h", bus.rd); end
    tests_run++; if (bus.rd !== 4'h0) begin tests_failed++; $display("[TB] FAIL rst_rd: got %h want 0", bus.rd); end
    tests_run++; if (bus.usb_data !== 16'h0) begin tests_failed++; $display("[TB] FAIL rst_data: got %h want 0", bus.usb_data); end
    tests_run++; if (busy !== 1'b0 || bus.usb_wr !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_ctl: got busy=%b wr=%b want 0/0", busy, bus.usb_wr); end
    cyc(2);
    rst = 1'b0;
    cyc(1);
    rdcnt_m[1] = env_cnt[1];
    seq_m = 4'd0; last_m = N_CH - 1;
    got_q.delete(); exp_q.delete();
    pulse_sw(4'b0001);
    wait_quiet(ok);
    model_block(0);
    tests_run++; if (!ok) begin tests_failed++; $display("[TB] FAIL rst_timeout: busy=%b", busy); end
    tests_run++; if (got_q.size() == 0 || got_q[0] !== 16'hA500) begin tests_failed++; $display("[TB] FAIL rst_header: got %0d words, first %h want A500", got_q.size(), got_q.size() ? got_q[0] : 16'h0); end
    tests_run++; if (got_q.size() !== exp_q.size()) begin tests_failed++; $display("[TB] FAIL rst_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests_run++; if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("[TB] FAIL rst_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    for (int c = 0; c < N_CH; c++) base[c] = 16'($urandom);
    test_reset();
    test_single();
    test_two_same_cycle();
    test_throttle();
    test_overrun();
    test_saturate();
    test_en_drop();
    test_random();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
